// File: rtl/regfile_pkg.sv
// Shared constants and types for the scoreboarded register file.
// Optional write-to-read bypass is selected with the REGFILE_BYPASS_EN macro.
package regfile_pkg;

  localparam int DEF_ADDRESS_WIDTH = 5;
  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_PEND_WIDTH    = 2;
  localparam int REG_ZERO          = 0;
  localparam int REG_A0            = 10;

  typedef logic [DEF_ADDRESS_WIDTH-1:0] reg_idx_t;
  typedef logic [DEF_PEND_WIDTH-1:0]    pend_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Bus between issue/writeback logic (master) and the scoreboarded register file (slave).
// Read addresses and data are packed per port so any READ_PORTS count fits one bundle.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int READ_PORTS    = 2
);

  logic                                    WE3;
  logic [ADDRESS_WIDTH-1:0]                AD3;
  logic [DATA_WIDTH-1:0]                   WD3;
  logic [READ_PORTS-1:0][ADDRESS_WIDTH-1:0] AD;
  logic [READ_PORTS-1:0][DATA_WIDTH-1:0]   RD;
  logic [READ_PORTS-1:0]                   RDY;
  logic                                    ISSUE;
  logic [ADDRESS_WIDTH-1:0]                ISSUE_AD;
  logic                                    ISSUE_RDY;
  logic [DATA_WIDTH-1:0]                   a0;

  modport master (
    output WE3, AD3, WD3, AD, ISSUE, ISSUE_AD,
    input  RD, RDY, ISSUE_RDY, a0
  );

  modport slave (
    input  WE3, AD3, WD3, AD, ISSUE, ISSUE_AD,
    output RD, RDY, ISSUE_RDY, a0
  );

endinterface

// File: rtl/regfile_sb_port.sv
// One combinational read port: zero-register handling, operand-ready logic and,
// when REGFILE_BYPASS_EN is defined, the writeback-to-read bypass mux.
module regfile_sb_port
  import regfile_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int PEND_WIDTH    = DEF_PEND_WIDTH
) (
  input  logic [ADDRESS_WIDTH-1:0] ad,
  input  logic [DATA_WIDTH-1:0]    arr_data,
  input  logic [PEND_WIDTH-1:0]    cnt,
`ifdef REGFILE_BYPASS_EN
  input  logic                     we,
  input  logic [ADDRESS_WIDTH-1:0] wr_ad,
  input  logic [DATA_WIDTH-1:0]    wr_data,
`endif
  output logic [DATA_WIDTH-1:0]    rd,
  output logic                     rdy
);

  logic is_zero;

  assign is_zero = (ad == ADDRESS_WIDTH'(REG_ZERO));

`ifdef REGFILE_BYPASS_EN
  logic hit;

  // A matching write retiring the last outstanding write makes the operand
  // usable now; a same-cycle issue is younger than this reader and is ignored.
  assign hit = we && (wr_ad == ad) && !is_zero;
  assign rd  = hit ? wr_data : arr_data;
  assign rdy = is_zero || (cnt == '0) || (hit && (cnt <= PEND_WIDTH'(1)));
`else
  assign rd  = arr_data;
  assign rdy = is_zero || (cnt == '0);
`endif

endmodule

// File: rtl/regfile_sb.sv
// Register file with one write port, READ_PORTS read ports and a per-register
// pending-write scoreboard; x0 is hard zero, a0 mirrors DEBUG_REG one cycle late.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int READ_PORTS    = 2,
  parameter int PEND_WIDTH    = DEF_PEND_WIDTH,
  parameter int DEBUG_REG     = REG_A0
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;

  logic [DATA_WIDTH-1:0] regs_reg [DEPTH];
  logic [PEND_WIDTH-1:0] cnt_reg  [DEPTH];
  logic [DATA_WIDTH-1:0] a0_reg;
  logic [DEPTH-1:0]      inc_vec;
  logic [DEPTH-1:0]      dec_vec;
  logic                  wr_en;
  logic                  issue_rdy;
  logic                  issue_acc;

  assign wr_en     = bus.WE3 && (bus.AD3 != ADDRESS_WIDTH'(REG_ZERO));
  assign issue_rdy = (bus.ISSUE_AD == ADDRESS_WIDTH'(REG_ZERO)) ||
                     (cnt_reg[bus.ISSUE_AD] != PEND_MAX);
  assign issue_acc = bus.ISSUE && issue_rdy &&
                     (bus.ISSUE_AD != ADDRESS_WIDTH'(REG_ZERO));

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (issue_acc) inc_vec[bus.ISSUE_AD] = 1'b1;
    if (wr_en)     dec_vec[bus.AD3]      = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) regs_reg[r] <= '0;
    end else if (wr_en) begin
      regs_reg[bus.AD3] <= bus.WD3;
    end
  end

  // Entry 0 never leaves reset. Issue+write on one register cancel out; a
  // write to an idle register leaves the count at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) cnt_reg[r] <= '0;
    end else begin
      for (int r = 1; r < DEPTH; r++) begin
        if (inc_vec[r] && !dec_vec[r]) begin
          cnt_reg[r] <= cnt_reg[r] + PEND_WIDTH'(1);
        end else if (dec_vec[r] && !inc_vec[r] && (cnt_reg[r] != '0)) begin
          cnt_reg[r] <= cnt_reg[r] - PEND_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) a0_reg <= '0;
    else     a0_reg <= regs_reg[DEBUG_REG];
  end

  assign bus.a0        = a0_reg;
  assign bus.ISSUE_RDY = issue_rdy;

  for (genvar gi = 0; gi < READ_PORTS; gi++) begin : g_port
    regfile_sb_port #(
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .DATA_WIDTH    (DATA_WIDTH),
      .PEND_WIDTH    (PEND_WIDTH)
    ) u_port (
      .ad       (bus.AD[gi]),
      .arr_data (regs_reg[bus.AD[gi]]),
      .cnt      (cnt_reg[bus.AD[gi]]),
`ifdef REGFILE_BYPASS_EN
      .we       (bus.WE3),
      .wr_ad    (bus.AD3),
      .wr_data  (bus.WD3),
`endif
      .rd       (bus.RD[gi]),
      .rdy      (bus.RDY[gi])
    );
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: expected values are queued as each step is
// driven and popped when the corresponding DUT output is sampled.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic clk;
  logic rst;
  exp_t exp_q[$];
  int   n_vec;
  int   n_err;

  regfile_sb_if #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .READ_PORTS(2)) bus ();

  regfile_sb #(
    .ADDRESS_WIDTH (5),
    .DATA_WIDTH    (32),
    .READ_PORTS    (2),
    .PEND_WIDTH    (2),
    .DEBUG_REG     (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: got %h, want queued value", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        n_err++;
        $error("FAIL %s: got %h, want %h", e.tag, obs, e.val);
      end
      $display("t=%0t %s obs=%h exp=%h", $time, e.tag, obs, e.val);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    rst          = 1'b1;
    bus.WE3      = 1'b0;
    bus.AD3      = '0;
    bus.WD3      = '0;
    bus.ISSUE    = 1'b0;
    bus.ISSUE_AD = '0;
    bus.AD[0]    = 5'd0;
    bus.AD[1]    = 5'd10;
    #2;
    push("rst_rd0", 32'h0);      chk(bus.RD[0]);
    push("rst_rd10", 32'h0);     chk(bus.RD[1]);
    push("rst_rdy", 32'h3);      chk(32'(bus.RDY));
    push("rst_issue_rdy", 32'h1); chk(32'(bus.ISSUE_RDY));
    push("rst_a0", 32'h0);       chk(bus.a0);
    step();
    step();
    rst = 1'b0;

    // Issue x5, then its writeback
    bus.ISSUE = 1'b1; bus.ISSUE_AD = 5'd5; bus.AD[0] = 5'd5;
    #1;
    push("pre_issue_rdy5", 32'h1); chk(32'(bus.RDY[0]));
    step();
    bus.ISSUE = 1'b0;
    #1;
    push("issue_rdy5", 32'h0); chk(32'(bus.RDY[0]));
    bus.WE3 = 1'b1; bus.AD3 = 5'd5; bus.WD3 = 32'hDEADBEEF;
    #1;
    push("wb_same_rd5", BYP ? 32'hDEADBEEF : 32'h0); chk(bus.RD[0]);
    push("wb_same_rdy5", BYP ? 32'h1 : 32'h0);        chk(32'(bus.RDY[0]));
    step();
    bus.WE3 = 1'b0;
    #1;
    push("wb_next_rd5", 32'hDEADBEEF); chk(bus.RD[0]);
    push("wb_next_rdy5", 32'h1);       chk(32'(bus.RDY[0]));

    // Saturate x7, fourth issue must be dropped
    bus.ISSUE = 1'b1; bus.ISSUE_AD = 5'd7; bus.AD[1] = 5'd7;
    repeat (3) step();
    push("sat_issue_rdy7", 32'h0); chk(32'(bus.ISSUE_RDY));
    step();
    bus.ISSUE = 1'b0;
    bus.WE3 = 1'b1; bus.AD3 = 5'd7; bus.WD3 = 32'h77;
    step();
    bus.WE3 = 1'b0;
    #1;
    push("unsat_issue_rdy7", 32'h1); chk(32'(bus.ISSUE_RDY));
    push("cnt2_rdy7", 32'h0);        chk(32'(bus.RDY[1]));
    bus.WE3 = 1'b1; bus.WD3 = 32'h78;
    step();
    bus.WE3 = 1'b0;
    #1;
    push("cnt1_rdy7", 32'h0); chk(32'(bus.RDY[1]));
    bus.WE3 = 1'b1; bus.WD3 = 32'h79;
    step();
    bus.WE3 = 1'b0;
    #1;
    push("cnt0_rdy7", 32'h1); chk(32'(bus.RDY[1]));
    push("cnt0_rd7", 32'h79); chk(bus.RD[1]);

    // Writes to x0 are discarded
    bus.WE3 = 1'b1; bus.AD3 = 5'd0; bus.WD3 = 32'h1234; bus.AD[0] = 5'd0;
    #1;
    push("x0_same_rd", 32'h0); chk(bus.RD[0]);
    step();
    bus.WE3 = 1'b0;
    #1;
    push("x0_next_rd", 32'h0);  chk(bus.RD[0]);
    push("x0_next_rdy", 32'h1); chk(32'(bus.RDY[0]));

    // a0 lags the array by one cycle
    bus.WE3 = 1'b1; bus.AD3 = 5'd10; bus.WD3 = 32'h55; bus.AD[1] = 5'd10;
    step();
    bus.WE3 = 1'b0;
    #1;
    push("a0_edge1", 32'h0);  chk(bus.a0);
    push("rd10_edge1", 32'h55); chk(bus.RD[1]);
    step();
    push("a0_edge2", 32'h55); chk(bus.a0);

    // Same-cycle issue and write to x3 with count 1
    bus.ISSUE = 1'b1; bus.ISSUE_AD = 5'd3; bus.AD[0] = 5'd3;
    step();
    bus.WE3 = 1'b1; bus.AD3 = 5'd3; bus.WD3 = 32'h33;
    #1;
    push("simul_same_rdy3", BYP ? 32'h1 : 32'h0);  chk(32'(bus.RDY[0]));
    push("simul_same_rd3", BYP ? 32'h33 : 32'h0);  chk(bus.RD[0]);
    step();
    bus.ISSUE = 1'b0; bus.WE3 = 1'b0;
    #1;
    push("simul_next_rdy3", 32'h0); chk(32'(bus.RDY[0]));
    push("simul_next_rd3", 32'h33); chk(bus.RD[0]);
    bus.WE3 = 1'b1; bus.WD3 = 32'h44;
    step();
    bus.WE3 = 1'b0;
    #1;
    push("retire_rdy3", 32'h1); chk(32'(bus.RDY[0]));
    // Write with count already 0: no underflow, data still lands
    bus.WE3 = 1'b1; bus.WD3 = 32'h45;
    step();
    bus.WE3 = 1'b0;
    #1;
    push("uflow_rdy3", 32'h1); chk(32'(bus.RDY[0]));
    push("uflow_rd3", 32'h45); chk(bus.RD[0]);
    bus.ISSUE = 1'b1;
    step();
    bus.ISSUE = 1'b0;
    #1;
    push("uflow_issue_rdy3", 32'h0); chk(32'(bus.RDY[0]));
    bus.WE3 = 1'b1; bus.WD3 = 32'h46;
    step();
    bus.WE3 = 1'b0;
    #1;
    push("uflow_retire_rdy3", 32'h1); chk(32'(bus.RDY[0]));

    // Mid-operation reset with x4 pending twice
    bus.WE3 = 1'b1; bus.AD3 = 5'd4; bus.WD3 = 32'h99;
    step();
    bus.WE3 = 1'b0;
    bus.ISSUE = 1'b1; bus.ISSUE_AD = 5'd4;
    step();
    step();
    bus.ISSUE = 1'b0; bus.AD[0] = 5'd4;
    #1;
    push("pend_rdy4", 32'h0);       chk(32'(bus.RDY[0]));
    push("pend_rd4", 32'h99);       chk(bus.RD[0]);
    push("pend_issue_rdy4", 32'h1); chk(32'(bus.ISSUE_RDY));
    #2;
    rst = 1'b1;
    #1;
    push("arst_rdy4", 32'h1); chk(32'(bus.RDY[0]));
    push("arst_rd4", 32'h0);  chk(bus.RD[0]);
    push("arst_a0", 32'h0);   chk(bus.a0);
    step();
    rst = 1'b0;

    if (exp_q.size() != 0) begin
      n_err++;
      $error("FAIL scoreboard_leftover: got %0d entries, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Clocked, parametrised integer register file with a configurable number of combinational read ports, one synchronous write port, and a per-register pending-write scoreboard. It replaces the single-cycle combinational register file in the decode stage of the pipelined core. Issue logic uses the scoreboard to detect RAW hazards, and an optional write-to-read bypass closes the writeback-to-decode gap. Register 0 reads as zero, and a debug port continuously exposes one architectural register (a0 by default).

## Interface
- ADDRESS_WIDTH, 5: register index width; depth is 2**ADDRESS_WIDTH.
- DATA_WIDTH, 32: register width.
- READ_PORTS, 2: number of independent read ports, minimum 1.
- PEND_WIDTH, 2: width of each per-register pending counter; at most 2**PEND_WIDTH-1 writes outstanding per register.
- DEBUG_REG, 10: index driven on a0.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- WE3  in  1  write enable.
- AD3  in  ADDRESS_WIDTH  write address.
- WD3  in  DATA_WIDTH  write data from writeback.
- AD  in  READ_PORTS x ADDRESS_WIDTH  read addresses.
- RD  out  READ_PORTS x DATA_WIDTH  read data.
- RDY  out  READ_PORTS  operand valid; no outstanding write.
- ISSUE  in  1  request to mark a destination pending.
- ISSUE_AD  in  ADDRESS_WIDTH  destination being issued.
- ISSUE_RDY  out  1  the issue request can be accepted.
- a0  out  DATA_WIDTH  registered copy of register DEBUG_REG.

## Operation
- **Storage:** 2**ADDRESS_WIDTH x DATA_WIDTH flops.
  - Register 0 is never written; reads of index 0 return 0 with RDY=1.
  - At the clock edge, WE3=1 with AD3≠0 stores WD3.
- **Scoreboard:** one PEND_WIDTH-bit unsigned counter per register; entry 0 is constant 0.
  - Issue accepted = ISSUE & ISSUE_RDY & (ISSUE_AD≠0). An accepted issue increments count[ISSUE_AD].
  - WE3 with AD3≠0 decrements count[AD3]. If the count is already 0 it stays 0: no underflow, but the data is still written.
  - Accepted issue and write to the same register in the same cycle: net count unchanged.
- **ISSUE_RDY** = (ISSUE_AD==0) or count[ISSUE_AD] < 2**PEND_WIDTH-1. Combinational; no accept when the counter is saturated, so no wrap-around.
- **RD[i]**, combinational: array[AD[i]], or the bypass value (see Configuration).
- **RDY[i]**, combinational: (AD[i]==0) or count[AD[i]]==0, or the bypass condition.
- **a0:** register updated every cycle from array[DEBUG_REG], taken after the write. a0 therefore trails the array by one cycle and is never bypassed.

## Timing
- **Reset** (asynchronous assert; release synchronised externally): all registers 0, all counters 0, a0=0.
  - During reset: RD=0, RDY all 1, ISSUE_RDY=1.
  - Reset mid-operation discards all outstanding pending counts.
- **Write latency:** WD3 is visible on RD one cycle after the write edge without bypass, and in the same cycle with bypass. It reaches a0 two edges after the write.
- **Issue latency:** an accepted issue at edge N makes RDY=0 for that register from cycle N+1.
- **Reads:** zero-latency combinational path from AD to RD/RDY.
- **Ports:** reads never stall writes; any number of ports may address the same register.

## Configuration
- Macro REGFILE_BYPASS_EN.
- **Defined:** for port i, if WE3 & AD3==AD[i] & AD[i]≠0, then RD[i]=WD3.
  - RDY[i]=1 when count[AD[i]]≤1, i.e. this write retires the last outstanding write.
  - A simultaneous accepted issue to the same register does not clear this RDY, because the reader predates the new issue.
- **Undefined:** RD[i] comes from the array only; RDY[i] depends only on the registered counter. A writeback-to-decode dependence costs one extra stall cycle.

## Structure
- **Shared package regfile_pkg:**
  - default ADDRESS_WIDTH/DATA_WIDTH constants;
  - REG_ZERO=0 and REG_A0=10 constants;
  - typedef for the register index;
  - typedef for the pending counter.
- **Sub-module regfile_sb_port:** one read port, instantiated READ_PORTS times in a generate loop. It holds the address match, bypass mux and RDY logic.
- The scoreboard counters stay in the top module.

## Test plan
- **Reset, then read:** assert rst, read AD={0,10} → RD={0,0}, RDY={1,1}, ISSUE_RDY=1, a0=0.
- **Issue then write:**
  - ISSUE with ISSUE_AD=5 → RDY for AD=5 drops next cycle.
  - Then WE3, AD3=5, WD3=0xDEADBEEF:
    - with bypass, RD=0xDEADBEEF and RDY=1 in the same cycle;
    - without bypass, both appear one cycle later.
- **Saturation (PEND_WIDTH=2):** three accepted issues to x7 → ISSUE_RDY=0 for ISSUE_AD=7. The fourth issue is ignored; one write to x7 restores ISSUE_RDY=1 and leaves count=2 (RDY still 0).
- **x0 and a0:**
  - WE3 to AD3=0 with WD3=0x1234 → RD for AD=0 stays 0.
  - A write of 0x55 to x10 → a0=0x55 after the second edge.
- **Simultaneous events:**
  - Same-cycle accepted issue and write to x3 with count=1 → count stays 1, RDY for x3 stays 0 next cycle.
  - A write to x3 when count=0 → count stays 0, data written.
- **Mid-operation reset:** with x4 pending (count=2) and x4=0x99, asserting rst → RDY for x4 becomes 1 and RD=0 immediately, without waiting for a clock edge.
